// File: rtl/stc_dbuf_sched.sv
`default_nettype none
// ============================================================================
// Module   : stc_dbuf_sched
// Purpose  : Double-buffer job scheduler. It walks a job through three steps:
//            LOAD fills the buffer row by row from memory, COMPUTE arbitrates
//            PE write ports per buffer row with a round-robin pointer, and
//            DRAIN reads the rows back out. A one-cycle done pulse follows
//            the last drained row.
// Options  : STC_DBUF_SCHED_CONFLICT_CNT_EN adds conflict_cnt[15:0]. It counts
//            the COMPUTE cycles in which at least one request was denied.
// Revision : 1.0 - initial release
// ============================================================================
module stc_dbuf_sched #(
  parameter int M      = 16,
  parameter int N_PE   = 4,
  parameter int DW_COL = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  output logic                     write_outside_en,
  output logic [DW_COL-1:0]        col_in,
  input  logic [N_PE-1:0]          pe_req,
  input  logic [N_PE*DW_COL-1:0]   pe_col,
  output logic [N_PE-1:0]          pe_gnt,
  input  logic                     compute_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW_COL-1:0]        col_out
`ifdef STC_DBUF_SCHED_CONFLICT_CNT_EN
  ,
  output logic [15:0]              conflict_cnt
`endif
);

  localparam int RRW = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam logic [DW_COL-1:0] LAST_ROW = DW_COL'(M - 1);
  localparam logic [RRW-1:0]    LAST_RR  = RRW'(N_PE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DW_COL-1:0] cnt_q, cnt_d;
  logic [RRW-1:0]    rr_q, rr_d;
  logic              done_q, done_d;
  logic              denied;

  // Distance of a PE from the round-robin pointer, walking upward modulo N_PE.
  // A smaller distance means a higher priority.
  function automatic int rr_dist(input int idx, input logic [RRW-1:0] rr);
    return (idx + N_PE - int'(rr)) % N_PE;
  endfunction

  // A requesting PE is granted unless a higher-priority PE wants the same row.
  always_comb begin
    pe_gnt = '0;
    if (state_q == COMPUTE) begin
      for (int i = 0; i < N_PE; i++) begin
        pe_gnt[i] = pe_req[i];
        for (int j = 0; j < N_PE; j++) begin
          if ((j != i) && pe_req[j] &&
              (pe_col[j*DW_COL +: DW_COL] == pe_col[i*DW_COL +: DW_COL]) &&
              (rr_dist(j, rr_q) < rr_dist(i, rr_q))) begin
            pe_gnt[i] = 1'b0;
          end
        end
      end
    end
  end

  assign denied = (state_q == COMPUTE) && (|(pe_req & ~pe_gnt));
  assign done   = done_q;

  // Compute the next state, the row counter, the pointer and the handshake outputs.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    rr_d             = rr_q;
    done_d           = 1'b0;
    mem_ready        = 1'b0;
    write_outside_en = 1'b0;
    col_in           = '0;
    out_valid        = 1'b0;
    col_out          = '0;
    busy             = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        mem_ready        = 1'b1;
        write_outside_en = mem_valid;
        col_in           = cnt_q;
        if (mem_valid) begin
          if (cnt_q == LAST_ROW) begin
            cnt_d   = '0;
            state_d = COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (denied) begin
          rr_d = (rr_q == LAST_RR) ? '0 : rr_q + 1'b1;
        end
        // Outstanding requests keep the job in COMPUTE until they are served.
        if (compute_done && (pe_req == '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        col_out   = cnt_q;
        if (out_ready) begin
          if (cnt_q == LAST_ROW) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register the state. Reset aborts any job without producing a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      done_q  <= done_d;
    end
  end

`ifdef STC_DBUF_SCHED_CONFLICT_CNT_EN
  // Count COMPUTE cycles with a denied request. The count saturates and clears when a job starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if ((state_q == IDLE) && start) begin
      conflict_cnt <= '0;
    end else if (denied && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/stc_dbuf_sched.md
STC_DBUF_SCHED -- requirements
Module: stc_dbuf_sched

Interface
REQ-001 SHALL have parameter M, default 16, number of buffer rows.
REQ-002 SHALL have parameter N_PE, default 4, number of PE write ports.
REQ-003 SHALL have parameter DW_COL, default 4, row-index width; M <= 2**DW_COL.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a load/compute/drain job.
REQ-007 SHALL have ports busy and done, both output 1: job active, and a one-cycle job-complete pulse.
REQ-008 SHALL have ports mem_valid  input  1  and mem_ready  output  1: memory-row handshake.
REQ-009 SHALL have ports write_outside_en  output  1  and col_in  output  DW_COL: buffer external write.
REQ-010 SHALL have ports pe_req  input  N_PE, pe_col  input  N_PE*DW_COL, and pe_gnt  output  N_PE; pe_gnt drives the buffer's write_inside_en and pe_col drives cols_in.
REQ-011 SHALL have port compute_done  input  1  PE array finished.
REQ-012 SHALL have ports out_valid  output  1, out_ready  input  1, and col_out  output  DW_COL: drain handshake and row select.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, COMPUTE, and DRAIN.
REQ-014 SHALL go IDLE->LOAD on start=1; start is ignored outside IDLE.
REQ-015 LOAD SHALL assert mem_ready=1, write_outside_en=mem_valid, col_in=row counter; counter increments on mem_valid&mem_ready.
REQ-016 SHALL go LOAD->COMPUTE on the handshake at counter=M-1; the counter then clears to 0.
REQ-017 COMPUTE SHALL grant, for each distinct requested pe_col value, exactly one requesting PE: the first at or after round-robin pointer rr, searching upward modulo N_PE.
REQ-018 Non-conflicting requests SHALL all be granted in the same cycle, combinationally (zero latency).
REQ-019 rr SHALL advance by 1 modulo N_PE at the end of every COMPUTE cycle in which at least one request was denied, and SHALL otherwise hold.
REQ-020 Denied PEs SHALL hold pe_req/pe_col; no grant starvation beyond N_PE-1 cycles for a steady request.
REQ-021 SHALL go COMPUTE->DRAIN when compute_done=1 and pe_req=0; if compute_done=1 with pe_req nonzero, grants issue and the state holds.
REQ-022 pe_gnt SHALL be 0 outside COMPUTE; write_outside_en SHALL be 0 outside LOAD.
REQ-023 DRAIN SHALL assert out_valid=1 with col_out=row counter; counter increments on out_valid&out_ready (buffer read data is combinational on col_out).
REQ-024 SHALL go DRAIN->IDLE on the handshake at counter=M-1, pulsing done=1 for exactly that following cycle, with the counter cleared.
REQ-025 busy SHALL be 1 in LOAD, COMPUTE, and DRAIN, and 0 in IDLE.
REQ-026 mem_ready and out_valid SHALL be 0 outside their states; col_in and col_out SHALL be 0 when unused.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, counter=0, rr=0, and all outputs 0, including mid-job; no done pulse on abort.
REQ-028 After reset_n deassertion the first job SHALL start only on a new start=1 sampled in IDLE.

Configuration
REQ-029 With macro STC_DBUF_SCHED_CONFLICT_CNT_EN defined, output conflict_cnt [15:0] SHALL count COMPUTE cycles with at least one denied request, saturating at 16'hFFFF and clearing on start accepted and on reset.
REQ-030 Without STC_DBUF_SCHED_CONFLICT_CNT_EN, the conflict_cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-031 M=16, start pulse, mem_valid=1 constantly -> col_in 0..15 on 16 consecutive cycles, then COMPUTE on cycle 17.
REQ-032 mem_valid toggling 1,0,1 during LOAD -> col_in holds while mem_valid=0, and write_outside_en=0 on that cycle.
REQ-033 pe_req=4'b1111, pe_col={3,3,5,3}, rr=0 -> pe_gnt=4'b0101; next cycle with PE0 and PE2 released, rr=1 -> pe_gnt=4'b0010, conflict_cnt=1 when the macro is defined.
REQ-034 compute_done=1 with pe_req=4'b0001 -> PE0 granted and state stays COMPUTE; next cycle pe_req=0 -> DRAIN.
REQ-035 DRAIN with out_ready low on alternate cycles -> col_out 0..15 each held while stalled, then done=1 for one cycle and busy=0.
REQ-036 reset_n=0 asserted during COMPUTE -> pe_gnt, busy, and done are 0 asynchronously, and the FSM is in IDLE after release.
